// File: rtl/stream_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stream_frame_controller                                          |
// | Brief   : Frame sequencer: locks blur enable per frame, tracks pixel       |
// |           coordinates and repairs short/long/overlapping frames.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stream_frame_controller #(
    parameter int                IMG_WIDTH  = 320,
    parameter int                IMG_HEIGHT = 240,
    parameter int                DATA_W     = 12,
    parameter logic [DATA_W-1:0] PAD_VALUE  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          valid_in,
    input  logic                          startofpacket_in,
    input  logic                          endofpacket_in,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          ready_out,
    output logic                          valid_out,
    output logic                          startofpacket_out,
    output logic                          endofpacket_out,
    output logic [DATA_W-1:0]             data_out,
    input  logic                          ready_in,
    input  logic                          blur_req,
    output logic                          is_underage,
    output logic [$clog2(IMG_WIDTH)-1:0]  x_pos,
    output logic [$clog2(IMG_HEIGHT)-1:0] y_pos,
    output logic [7:0]                    frame_count,
    output logic                          err_short,
    output logic                          err_long,
    output logic                          err_sop
);

    localparam int c_X_W = $clog2(IMG_WIDTH);
    localparam int c_Y_W = $clog2(IMG_HEIGHT);
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(IMG_WIDTH - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_PAD    = 2'd2,
        S_DROP   = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic              r_valid, r_sop, r_eop, r_underage;
    logic [DATA_W-1:0] r_data;
    logic [c_X_W-1:0]  r_x, r_nx;
    logic [c_Y_W-1:0]  r_y, r_ny;
    logic [7:0]        r_frame_count;
    logic              r_err_short, r_err_long, r_err_sop;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_hold_eop, r_hold_full, r_pad_done;

    logic              w_slot_free, w_accept, w_at_last;
    logic              w_load, w_ld_sop, w_ld_eop, w_ld_first, w_latch_u, w_fc_inc;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_err_short, w_err_long, w_err_sop;
    logic              w_hold_set, w_hold_clr, w_pad_last;

    assign w_slot_free = ~r_valid | ready_in;
    assign ready_out   = (r_state != S_PAD) & ~r_hold_full & w_slot_free;
    assign w_accept    = valid_in & ready_out;
    // r_nx/r_ny always point at the coordinate the next non-sop load will take
    assign w_at_last   = (r_nx == c_X_LAST) && (r_ny == c_Y_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_ld_data   = data_in;
        w_ld_sop    = 1'b0;
        w_ld_eop    = 1'b0;
        w_ld_first  = 1'b0;
        w_latch_u   = 1'b0;
        w_fc_inc    = 1'b0;
        w_err_short = 1'b0;
        w_err_long  = 1'b0;
        w_err_sop   = 1'b0;
        w_hold_set  = 1'b0;
        w_hold_clr  = 1'b0;
        w_pad_last  = 1'b0;
        case (r_state)
            S_IDLE, S_DROP: begin
                if (w_accept && startofpacket_in) begin
                    w_load     = 1'b1;
                    w_ld_sop   = 1'b1;
                    w_ld_first = 1'b1;
                    w_latch_u  = 1'b1;
                    if (endofpacket_in) begin
                        w_ld_eop    = 1'b1;
                        w_fc_inc    = 1'b1;
                        w_err_short = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (w_accept) begin
                    if (startofpacket_in) begin
                        w_hold_set  = 1'b1;
                        w_err_sop   = 1'b1;
                        w_state_nxt = S_PAD;
                    end else begin
                        w_load = 1'b1;
                        if (endofpacket_in) begin
                            w_ld_eop    = 1'b1;
                            w_fc_inc    = 1'b1;
                            w_err_short = ~w_at_last;
                            w_state_nxt = S_IDLE;
                        end else if (w_at_last) begin
                            w_ld_eop    = 1'b1;
                            w_fc_inc    = 1'b1;
                            w_err_long  = 1'b1;
                            w_state_nxt = S_DROP;
                        end
                    end
                end
            end
            S_PAD: begin
                if (w_slot_free) begin
                    w_load = 1'b1;
                    if (!r_pad_done) begin
                        w_ld_data = PAD_VALUE;
                        if (w_at_last) begin
                            w_ld_eop   = 1'b1;
                            w_fc_inc   = 1'b1;
                            w_pad_last = 1'b1;
                        end
                    end else begin
                        // held sop beat opens the next frame
                        w_ld_data  = r_hold_data;
                        w_ld_sop   = 1'b1;
                        w_ld_first = 1'b1;
                        w_latch_u  = 1'b1;
                        w_hold_clr = 1'b1;
                        if (r_hold_eop) begin
                            w_ld_eop    = 1'b1;
                            w_fc_inc    = 1'b1;
                            w_err_short = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_ACTIVE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_sop         <= 1'b0;
            r_eop         <= 1'b0;
            r_data        <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_nx          <= '0;
            r_ny          <= '0;
            r_underage    <= 1'b0;
            r_frame_count <= '0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
            r_err_sop     <= 1'b0;
            r_hold_data   <= '0;
            r_hold_eop    <= 1'b0;
            r_hold_full   <= 1'b0;
            r_pad_done    <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_ld_data;
                r_sop   <= w_ld_sop;
                r_eop   <= w_ld_eop;
                if (w_ld_first) begin
                    r_x  <= '0;
                    r_y  <= '0;
                    r_nx <= c_X_W'(1);
                    r_ny <= '0;
                end else begin
                    r_x <= r_nx;
                    r_y <= r_ny;
                    if (r_nx == c_X_LAST) begin
                        r_nx <= '0;
                        r_ny <= (r_ny == c_Y_LAST) ? '0 : r_ny + 1'b1;
                    end else begin
                        r_nx <= r_nx + 1'b1;
                    end
                end
            end else if (w_slot_free) begin
                r_valid <= 1'b0;
                r_sop   <= 1'b0;
                r_eop   <= 1'b0;
            end
            if (w_latch_u) r_underage <= blur_req;
            if (w_fc_inc)  r_frame_count <= r_frame_count + 8'd1;
            r_err_short <= w_err_short;
            r_err_long  <= w_err_long;
            r_err_sop   <= w_err_sop;
            if (w_hold_set) begin
                r_hold_data <= data_in;
                r_hold_eop  <= endofpacket_in;
                r_hold_full <= 1'b1;
            end else if (w_hold_clr) begin
                r_hold_full <= 1'b0;
            end
            if (w_pad_last)      r_pad_done <= 1'b1;
            else if (w_hold_clr) r_pad_done <= 1'b0;
        end
    end

    assign valid_out         = r_valid;
    assign startofpacket_out = r_sop;
    assign endofpacket_out   = r_eop;
    assign data_out          = r_data;
    assign x_pos             = r_x;
    assign y_pos             = r_y;
    assign is_underage       = r_underage;
    assign frame_count       = r_frame_count;
    assign err_short         = r_err_short;
    assign err_long          = r_err_long;
    assign err_sop           = r_err_sop;

endmodule

`default_nettype wire

// File: tb/tb_stream_frame_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_stream_frame_controller                                       |
// | Brief   : Scoreboard bench for stream_frame_controller on a 6x4 frame.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_stream_frame_controller;

    localparam int          W    = 6;
    localparam int          H    = 4;
    localparam int          FS   = W * H;
    localparam logic [11:0] PADV = 12'h5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0, sop_in = 1'b0, eop_in = 1'b0;
    logic [11:0] data_in = '0;
    logic        ready_out, valid_out, sop_out, eop_out;
    logic [11:0] data_out;
    logic        ready_in = 1'b1, blur_req = 1'b0, is_underage;
    logic [2:0]  x_pos;
    logic [1:0]  y_pos;
    logic [7:0]  frame_count;
    logic        err_short, err_long, err_sop;

    stream_frame_controller #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(12), .PAD_VALUE(PADV)
    ) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .startofpacket_in(sop_in), .endofpacket_in(eop_in),
        .data_in(data_in), .ready_out(ready_out),
        .valid_out(valid_out), .startofpacket_out(sop_out), .endofpacket_out(eop_out),
        .data_out(data_out), .ready_in(ready_in),
        .blur_req(blur_req), .is_underage(is_underage),
        .x_pos(x_pos), .y_pos(y_pos), .frame_count(frame_count),
        .err_short(err_short), .err_long(err_long), .err_sop(err_sop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] d;
        logic        s;
        logic        e;
        logic        u;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [7:0]  fc;
    } beat_t;

    beat_t      exp_q[$];
    logic [2:0] err_q[$];
    int         vectors = 0, miscompares = 0;

    // Reference model: frame as a beat index 0..FS-1, coordinates by div/mod
    bit   m_in = 0;
    int   m_n = 0, m_fc = 0;
    logic m_u = 1'b0;

    function automatic void m_emit(logic [11:0] d, logic s, logic e, int n);
        beat_t b;
        b.d = d; b.s = s; b.e = e; b.u = m_u;
        b.x = 8'(n % W); b.y = 8'(n / W); b.fc = 8'(m_fc);
        exp_q.push_back(b);
    endfunction

    function automatic void m_start(logic [11:0] d, logic e, logic req);
        m_u = req;
        if (e) begin
            m_fc = (m_fc + 1) % 256;
            m_emit(d, 1'b1, 1'b1, 0);
            err_q.push_back(3'b100);
            m_in = 0;
        end else begin
            m_emit(d, 1'b1, 1'b0, 0);
            m_in = 1;
            m_n  = 1;
        end
    endfunction

    function automatic void m_accept(logic s, logic e, logic [11:0] d, logic req);
        bit last;
        if (!m_in) begin
            if (s) m_start(d, e, req);
        end else if (s) begin
            err_q.push_back(3'b001);
            for (int n = m_n; n < FS; n++) begin
                if (n == FS - 1) m_fc = (m_fc + 1) % 256;
                m_emit(PADV, 1'b0, n == FS - 1, n);
            end
            m_in = 0;
            m_start(d, e, req);
        end else begin
            last = (m_n == FS - 1);
            if (e || last) begin
                m_fc = (m_fc + 1) % 256;
                m_emit(d, 1'b0, 1'b1, m_n);
                m_in = 0;
                if (e && !last) err_q.push_back(3'b100);
                else if (!e)    err_q.push_back(3'b010);
            end else begin
                m_emit(d, 1'b0, 1'b0, m_n);
                m_n++;
            end
        end
    endfunction

    // Monitor: everything sampled mid-cycle, ahead of the edge that acts on it
    logic        prev_stall = 1'b0;
    logic [13:0] prev_beat;
    always @(negedge clk) begin
        beat_t      act, ex;
        logic [2:0] ecode, eexp;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (!valid_out || {data_out, sop_out, eop_out} !== prev_beat) begin
                    miscompares++;
                    $display("FAIL hold_stable: got v=%b d=%h s=%b e=%b, want v=1 {d,s,e}=%h",
                             valid_out, data_out, sop_out, eop_out, prev_beat);
                end
            end
            ecode = {err_short, err_long, err_sop};
            if (ecode != 3'b000) begin
                vectors++;
                if (err_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL err_pulse: got %b, want none", ecode);
                end else begin
                    eexp = err_q.pop_front();
                    if (ecode !== eexp) begin
                        miscompares++;
                        $display("FAIL err_pulse: got %b, want %b", ecode, eexp);
                    end
                end
            end
            if (valid_out && ready_in) begin
                vectors++;
                act.d = data_out; act.s = sop_out; act.e = eop_out; act.u = is_underage;
                act.x = 8'(x_pos); act.y = 8'(y_pos); act.fc = frame_count;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat: got d=%h s=%b e=%b at (%0d,%0d), want no beat",
                             act.d, act.s, act.e, act.x, act.y);
                end else begin
                    ex = exp_q.pop_front();
                    if (act !== ex) begin
                        miscompares++;
                        $display("FAIL beat: got d=%h s=%b e=%b u=%b (%0d,%0d) fc=%0d, want d=%h s=%b e=%b u=%b (%0d,%0d) fc=%0d",
                                 act.d, act.s, act.e, act.u, act.x, act.y, act.fc,
                                 ex.d, ex.s, ex.e, ex.u, ex.x, ex.y, ex.fc);
                    end
                end
            end
            prev_stall = valid_out & ~ready_in;
            prev_beat  = {data_out, sop_out, eop_out};
            if (valid_in && ready_out) m_accept(sop_in, eop_in, data_in, blur_req);
        end
    end

    // 0: always ready, 1: random, 2: 5 low out of every 15 cycles
    int rdy_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            1:       ready_in = ($urandom % 4) != 0;
            2:       ready_in = (cyc % 15) >= 5;
            default: ready_in = 1'b1;
        endcase
    end

    task automatic send(input logic s, input logic e, input logic [11:0] d, input logic req);
        int t = 0;
        valid_in = 1'b1; sop_in = s; eop_in = e; data_in = d; blur_req = req;
        forever begin
            @(negedge clk);
            if (ready_out) break;
            t++;
            if (t > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: ready_out stuck at 0, want 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({valid_out, sop_out, eop_out, data_out, x_pos, y_pos, is_underage,
             frame_count, err_short, err_long, err_sop} !== '0) begin
            miscompares++;
            $display("FAIL %s: got v=%b d=%h (%0d,%0d) u=%b fc=%0d errs=%b%b%b, want all 0",
                     name, valid_out, data_out, x_pos, y_pos, is_underage, frame_count,
                     err_short, err_long, err_sop);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        logic s, e, req, prev_s;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        reset = 1'b0;
        idle(2);

        // clean frame, blur on, no backpressure
        for (int i = 0; i < FS; i++) begin
            send(i == 0, i == FS - 1, 12'(i + 1), 1'b1);
            if (i == 0) check_val("first_latency", int'(valid_out & sop_out), 1);
        end
        idle(3);
        check_val("frame_count_1", int'(frame_count), 1);
        check_val("underage_1", int'(is_underage), 1);

        // backpressure pattern with input gaps
        rdy_mode = 2;
        for (int i = 0; i < FS; i++) begin
            send(i == 0, i == FS - 1, 12'(12'h100 + i), 1'b0);
            if (i % 7 == 6) idle(1);
        end

        // short frame: eop on beat 10 at (3,1), then a clean frame
        rdy_mode = 1;
        for (int i = 0; i < 10; i++) send(i == 0, i == 9, 12'(12'h200 + i), 1'b1);
        for (int i = 0; i < FS; i++) send(i == 0, i == FS - 1, 12'(12'h300 + i), 1'b0);

        // long frame plus trailing junk, then a clean frame
        for (int i = 0; i < FS + 5; i++) send(i == 0, 1'b0, 12'(12'h400 + i), 1'b1);
        for (int i = 0; i < FS; i++) send(i == 0, i == FS - 1, 12'(12'h500 + i), 1'b1);

        // sop after 5 beats: pad the rest, held beat opens the next frame
        for (int i = 0; i < 5; i++) send(i == 0, 1'b0, 12'(12'h600 + i), 1'b0);
        send(1'b1, 1'b0, 12'hABC, 1'b1);
        for (int i = 1; i < FS; i++) send(1'b0, i == FS - 1, 12'(12'h700 + i), 1'b1);
        idle(4);

        // randomized traffic
        prev_s = 1'b0;
        req    = 1'b0;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom % 18) == 0;
            e = ($urandom % 20) == 0;
            if (!prev_s) req = 1'($urandom % 2);
            send(s, e, 12'($urandom), req);
            prev_s = s;
            if (($urandom % 6) == 0) idle($urandom_range(1, 3));
        end
        for (int i = 0; i < FS; i++) send(i == 0, i == FS - 1, 12'(12'h800 + i), req);
        idle(4);

        // blur_req rises mid-frame: ignored until the next sop
        rdy_mode = 0;
        for (int i = 0; i < FS; i++) send(i == 0, i == FS - 1, 12'(12'h900 + i), i >= 8);
        for (int i = 0; i < 10; i++) send(i == 0, 1'b0, 12'(12'hA00 + i), 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_midframe");
        exp_q.delete();
        err_q.delete();
        m_in = 0; m_n = 0; m_fc = 0; m_u = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < FS; i++) send(i == 0, i == FS - 1, 12'(12'hB00 + i), 1'b1);

        for (int i = 0; i < 400 && (exp_q.size() != 0 || valid_out); i++) @(posedge clk);
        idle(3);
        check_val("beats_left", exp_q.size(), 0);
        check_val("errs_left", err_q.size(), 0);
        check_val("frame_count_final", int'(frame_count), m_fc);
        check_val("underage_final", int'(is_underage), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stream_frame_controller.md
Name: stream_frame_controller

Overview:
- Frame-level sequencer in front of blurring_filter.
- Sits between the camera pixel stream (RGB444, 320x240, valid/ready with sop/eop) and the filter's sink.
- Locks the blur-enable control at frame boundaries and tracks pixel coordinates.
- Repairs malformed frames so the filter always sees exactly IMG_WIDTH*IMG_HEIGHT beats per packet, framed by exactly one sop and one eop.

Parameters:
IMG_WIDTH, 320, pixels per line
IMG_HEIGHT, 240, lines per frame
DATA_W, 12, pixel width (RGB444)
PAD_VALUE, 12'h000, data emitted on padded beats

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  upstream beat valid
startofpacket_in  in  1  upstream sop
endofpacket_in  in  1  upstream eop
data_in  in  DATA_W  upstream pixel
ready_out  out  1  controller can accept upstream beat
valid_out  out  1  beat to filter valid
startofpacket_out  out  1  sop to filter
endofpacket_out  out  1  eop to filter
data_out  out  DATA_W  pixel to filter
ready_in  in  1  filter ready
blur_req  in  1  asynchronous-to-frame blur request (is_underage source)
is_underage  out  1  blur enable to filter, frame-stable
x_pos  out  $clog2(IMG_WIDTH)  column of beat in output register
y_pos  out  $clog2(IMG_HEIGHT)  row of beat in output register
frame_count  out  8  completed frames, wraps 255->0
err_short  out  1  1-cycle pulse: eop before full frame
err_long  out  1  1-cycle pulse: frame reached full count without eop
err_sop  out  1  1-cycle pulse: sop mid-frame

Behaviour:
- Reset (async): all outputs 0; state IDLE; pixel counter 0; hold register empty.
- Output stage: single register. Beat loads when the slot is empty or ready_in=1. valid_out holds with stable data/sop/eop until ready_in=1. Pass-through latency is 1 cycle.
- Upstream handshake: accept = valid_in & ready_out.
- ready_out = (state!=PAD) & ~hold_full & (~valid_out | ready_in). ready_out must not depend on valid_in.
- Counter: increments on every load into the output register (forwarded or padded). x_pos/y_pos reflect the loaded beat. x wraps at IMG_WIDTH-1 and increments y. Last beat is at (IMG_WIDTH-1, IMG_HEIGHT-1).
- States:
  - IDLE: accepted beats without sop are discarded (not forwarded). An accepted sop beat:
    - latches is_underage<=blur_req;
    - is forwarded with startofpacket_out=1 at (0,0);
    - moves to ACTIVE.
  - ACTIVE: accepted beats are forwarded.
    - eop_in on the last beat: forward with eop_out, frame_count++, go IDLE.
    - eop_in earlier: forward with eop_out, pulse err_short, frame_count++, go IDLE (short frame passed as-is).
    - Last beat without eop_in: force endofpacket_out=1, pulse err_long, frame_count++, go DROP.
    - sop_in mid-frame: store the beat in the hold register (not forwarded), pulse err_sop, go PAD.
  - PAD: ready_out=0. Load PAD_VALUE beats (sop=0) as the output slot frees. The final beat carries eop_out=1; then frame_count++. Next, the held beat is loaded as a new frame: sop_out=1, is_underage re-latched from blur_req at that load, hold cleared, go ACTIVE.
  - DROP: accepted non-sop beats are discarded. An accepted sop is handled exactly as in IDLE.
- sop_in & eop_in on the same beat in IDLE: forward with both flags, pulse err_short, frame_count++, stay IDLE.
- is_underage changes only at a sop load; blur_req toggles mid-frame are ignored until the next frame.
- Error pulses fire in the cycle after the triggering accept. Multiple errors never coincide on one beat.
- Reset asserted mid-frame: output beat dropped, hold discarded, is_underage=0, frame_count=0.

Test Plan:
- Clean 320x240 frame, valid_in=1, ready_in=1, blur_req=1 -> 76800 beats out, sop only at (0,0), eop only at (319,239), is_underage=1, frame_count=1, first valid_out 1 cycle after first accept, no error pulses.
- Backpressure: ready_in low for 5 cycles every 10th beat, valid_in gapped every 7th beat -> output sequence identical to input, data never changes while valid_out=1 & ready_in=0.
- Early eop after 1000 beats -> 1000 beats out with eop on beat 1000 at (39,3), err_short=1 for one cycle, state IDLE; next frame starts clean at (0,0).
- No eop on beat 76800 followed by 50 extra non-sop beats -> eop_out forced on beat 76800, err_long pulse, 50 beats discarded (no valid_out), next sop frame forwarded normally.
- sop after 500 beats -> err_sop pulse, 76300 beats of PAD_VALUE with eop on the last, then held pixel out with sop_out=1 at (0,0), frame_count incremented by 1.
- blur_req toggled 0->1 at beat 100 of a frame -> is_underage stays 0 for the rest of that frame, goes 1 at the next sop; reset asserted at beat 200 -> all outputs 0 immediately, frame_count=0.
